// File: rtl/controle_divisao_pkg.sv
// Shared definitions for the restoring divider controller.
//   W_DEF / CNT_W_DEF : default operand and iteration-counter widths
//   estado_t          : FSM state encoding (2'd3 is unused and recovers to OCIOSO)
package controle_divisao_pkg;
    localparam int W_DEF     = 12;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;
endpackage

// File: rtl/controle_divisao_if.sv
// Handshake and operand/result bus of the divider.
//   start, dividendo, divisor       : request side (driven by master)
//   quociente, resto, busy, done,
//   div_zero                        : response side (driven by slave)
interface controle_divisao_if #(
    parameter int W = controle_divisao_pkg::W_DEF
);
    logic         start;
    logic [W-1:0] dividendo;
    logic [W-1:0] divisor;
    logic [W-1:0] quociente;
    logic [W-1:0] resto;
    logic         busy;
    logic         done;
    logic         div_zero;

    modport master (
        output start, dividendo, divisor,
        input  quociente, resto, busy, done, div_zero
    );
    modport slave (
        input  start, dividendo, divisor,
        output quociente, resto, busy, done, div_zero
    );
endinterface

// File: rtl/controle_divisao_etapa_divisao.sv
// One restoring-division step (purely combinational).
//   r_i       : current partial remainder
//   msb_i     : next dividend bit to shift in
//   d_i       : divisor
//   r_next_o  : partial remainder after the trial subtraction
//   q_bit_o   : quotient bit produced by this step
module etapa_divisao #(
    parameter int W = controle_divisao_pkg::W_DEF
) (
    input  logic [W-1:0] r_i,
    input  logic         msb_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] r_next_o,
    output logic         q_bit_o
);
    logic [W-1:0] r_sh;
    logic [W:0]   t;

    assign r_sh = {r_i[W-2:0], msb_i};
    // The bit shifted out of R is kept as a guard so the subtraction is
    // done on the true W+1-bit value; needed when D > 2^(W-1).
    assign t    = {r_i[W-1], r_sh} - {1'b0, d_i};

    assign q_bit_o  = ~t[W];
    // When T >= 0 it is smaller than D, so the low W bits hold it exactly.
    assign r_next_o = q_bit_o ? t[W-1:0] : r_sh;
endmodule

// File: rtl/controle_divisao.sv
// Sequential controller for a W-bit unsigned restoring divider.
// Owns the operand registers, iteration counter and start/done handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : start/operands in, quociente/resto/busy/done/div_zero out
module controle_divisao
    import controle_divisao_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    controle_divisao_if.slave  bus
);
    estado_t         estado_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]    dvd_q;
    logic [W-1:0]    d_q;
    logic [W-1:0]    r_q;
    logic [W-1:0]    q_q;
    logic [W-1:0]    quoc_q;
    logic [W-1:0]    resto_q;
    logic            busy_q;
    logic            done_q;
    logic            dz_q;

    logic [W-1:0]    r_d;
    logic            q_bit;
    logic [W-1:0]    q_d;

    etapa_divisao #(.W(W)) u_etapa (
        .r_i      (r_q),
        .msb_i    (dvd_q[W-1]),
        .d_i      (d_q),
        .r_next_o (r_d),
        .q_bit_o  (q_bit)
    );

    assign q_d = {q_q[W-2:0], q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            dvd_q    <= '0;
            d_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            quoc_q   <= '0;
            resto_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.divisor == '0) begin
                            // Divide by zero skips the iterations entirely.
                            quoc_q   <= '1;
                            resto_q  <= bus.dividendo;
                            dz_q     <= 1'b1;
                            done_q   <= 1'b1;
                            estado_q <= FIM;
                        end else begin
                            dvd_q    <= bus.dividendo;
                            d_q      <= bus.divisor;
                            r_q      <= '0;
                            q_q      <= '0;
                            cnt_q    <= CNT_W'(W - 1);
                            dz_q     <= 1'b0;
                            estado_q <= CALCULA;
                        end
                    end
                end
                CALCULA: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    dvd_q <= {dvd_q[W-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        // Last iteration: publish this step's values directly.
                        quoc_q   <= q_d;
                        resto_q  <= r_d;
                        done_q   <= 1'b1;
                        estado_q <= FIM;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FIM: begin
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    estado_q <= OCIOSO;
                end
                default: begin
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.quociente = quoc_q;
    assign bus.resto     = resto_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_controle_divisao.sv
// Scoreboard bench: the driver pushes expected results, a monitor pops and
// compares on every done pulse (value, div_zero and arrival cycle).
module tb_controle_divisao;
    localparam int W = 12;

    logic clk;
    logic rst_n;
    int   cyc;
    int   ntests;
    int   nfail;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           at;
    } exp_t;
    exp_t sb[$];

    controle_divisao_if #(.W(W)) bus ();

    controle_divisao #(.W(W), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quociente", 32'(bus.quociente), 32'(e.q));
                chk("resto", 32'(bus.resto), 32'(e.r));
                chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
                chk("done_cycle", 32'(cyc), 32'(e.at));
                chk("busy_at_done", 32'(bus.busy), 32'd1);
            end
        end
    end

    // Issue one start; returns on the negedge after acceptance with start low.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int k;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dividendo = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        k = cyc;
        sb.push_back('{eq, er, edz, k + ((b == '0) ? 0 : W)});
        @(negedge clk);
        bus.start     = 1'b0;
        bus.dividendo = 12'hA5A;
        bus.divisor   = 12'h5A5;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            ntests++;
            nfail++;
            $display("FAIL timeout: %0d results still pending", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_quociente"}, 32'(bus.quociente), 32'd0);
        chk({tag, "_resto"}, 32'(bus.resto), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_div_zero"}, 32'(bus.div_zero), 32'd0);
    endtask

    initial begin
        int k;
        ntests        = 0;
        nfail         = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.dividendo = '0;
        bus.divisor   = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_div(12'd100, 12'd7, 12'h00E, 12'h002, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("hold_quociente", 32'(bus.quociente), 32'h00E);
        chk("hold_resto", 32'(bus.resto), 32'h002);

        do_div(12'hFFF, 12'h801, 12'h001, 12'h7FE, 1'b0);
        wait_idle();
        do_div(12'd123, 12'd0, 12'hFFF, 12'h07B, 1'b1);
        wait_idle();
        do_div(12'd5, 12'd9, 12'h000, 12'h005, 1'b0);
        wait_idle();
        do_div(12'hFFF, 12'd1, 12'hFFF, 12'h000, 1'b0);
        wait_idle();

        // Start pulse during CALCULA must be ignored.
        do_div(12'd100, 12'd7, 12'h00E, 12'h002, 1'b0);
        repeat (4) @(negedge clk);
        bus.start     = 1'b1;
        bus.dividendo = 12'd9;
        bus.divisor   = 12'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Start held high: second division begins on the first OCIOSO cycle after FIM.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dividendo = 12'd20;
        bus.divisor   = 12'd3;
        @(posedge clk);
        #1;
        k = cyc;
        sb.push_back('{12'd6, 12'd2, 1'b0, k + W});
        sb.push_back('{12'd8, 12'd2, 1'b0, k + W + 2 + W});
        @(negedge clk);
        bus.dividendo = 12'd50;
        bus.divisor   = 12'd6;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < k + W + 2);
        bus.start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of a division.
        do_div(12'd100, 12'd7, 12'h00E, 12'h002, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_div(12'hFFF, 12'd1, 12'hFFF, 12'h000, 1'b0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
